// File: rtl/generic_fifo_v2.sv
// Parameterised synchronous FIFO with occupancy counter, sticky over/underflow flags
// and a selectable registered-read or first-word-fall-through output.
module generic_fifo_v2 #(
    parameter int GENERIC_FIFO_DEPTH      = 8,
    parameter int GENERIC_FIFO_DATA_WIDTH = 32,
    parameter int GENERIC_FIFO_THRESHOLD  = 2,
    parameter int GENERIC_FIFO_FWFT       = 0
) (
    input  logic                               clk,
    input  logic                               reset_poweron,
    input  logic                               clear,
    input  logic                               write,
    input  logic [GENERIC_FIFO_DATA_WIDTH-1:0] write_data,
    input  logic                               read,
    output logic [GENERIC_FIFO_DATA_WIDTH-1:0] read_data,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_full,
    output logic [$clog2(GENERIC_FIFO_DEPTH):0] count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int AW = $clog2(GENERIC_FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(GENERIC_FIFO_DEPTH);
    localparam logic [AW:0] AF_LEVEL   = (AW+1)'(GENERIC_FIFO_DEPTH - GENERIC_FIFO_THRESHOLD);

    logic [GENERIC_FIFO_DATA_WIDTH-1:0] mem_r [GENERIC_FIFO_DEPTH];
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          overflow_r;
    logic          underflow_r;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          op_en_s;

    // Flags come from the registered count only, never from pointer comparison.
    assign empty       = (count_r == (AW+1)'(0));
    assign full        = (count_r == FULL_LEVEL);
    assign almost_full = (count_r >= AF_LEVEL);
    assign count       = count_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

    assign op_en_s  = ~reset_poweron & ~clear;
    assign rd_acc_s = read & ~empty;
    assign wr_acc_s = write & (~full | rd_acc_s);

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and sticky-flag state with reset > clear > traffic priority.
    always_ff @(posedge clk) begin
        if (reset_poweron || clear) begin
            wp_r        <= AW'(0);
            rp_r        <= AW'(0);
            count_r     <= (AW+1)'(0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wp_r <= wp_r + AW'(1);
            end
            if (rd_acc_s) begin
                rp_r <= rp_r + AW'(1);
            end
            count_r <= count_next_s;
            if (write && !wr_acc_s) begin
                overflow_r <= 1'b1;
            end
            if (read && empty) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Storage array; deliberately has no reset.
    always_ff @(posedge clk) begin
        if (op_en_s && wr_acc_s) begin
            mem_r[wp_r] <= write_data;
        end
    end

    generate
        if (GENERIC_FIFO_FWFT != 0) begin : g_fwft
            assign read_data = mem_r[rp_r];
        end else begin : g_reg_read
            // Registered read port: loads the head word on an accepted pop, holds otherwise.
            always_ff @(posedge clk) begin
                if (reset_poweron) begin
                    read_data <= {GENERIC_FIFO_DATA_WIDTH{1'b0}};
                end else if (!clear && rd_acc_s) begin
                    read_data <= mem_r[rp_r];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_generic_fifo_v2.sv
// Directed bench: a registered-read and a FWFT instance share one stimulus stream.
module tb_generic_fifo_v2;

    logic       clk = 1'b0;
    logic       reset_poweron = 1'b1;
    logic       clear = 1'b0;
    logic       write = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       read = 1'b0;

    logic [7:0] rd0, rd1;
    logic       empty0, full0, af0, ovf0, udf0;
    logic       empty1, full1, af1, ovf1, udf1;
    logic [3:0] count0, count1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    generic_fifo_v2 #(.GENERIC_FIFO_DEPTH(8), .GENERIC_FIFO_DATA_WIDTH(8),
                      .GENERIC_FIFO_THRESHOLD(2), .GENERIC_FIFO_FWFT(0)) dut_reg (
        .clk(clk), .reset_poweron(reset_poweron), .clear(clear), .write(write),
        .write_data(write_data), .read(read), .read_data(rd0), .empty(empty0),
        .full(full0), .almost_full(af0), .count(count0), .overflow(ovf0), .underflow(udf0));

    generic_fifo_v2 #(.GENERIC_FIFO_DEPTH(8), .GENERIC_FIFO_DATA_WIDTH(8),
                      .GENERIC_FIFO_THRESHOLD(2), .GENERIC_FIFO_FWFT(1)) dut_fwft (
        .clk(clk), .reset_poweron(reset_poweron), .clear(clear), .write(write),
        .write_data(write_data), .read(read), .read_data(rd1), .empty(empty1),
        .full(full1), .almost_full(af1), .count(count1), .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge with inputs idle.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic c, input logic rst);
        write = w; write_data = d; read = r; clear = c; reset_poweron = rst;
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0; clear = 1'b0; reset_poweron = 1'b0;
    endtask

    initial begin
        #1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_af", 32'(af0), 32'd0);
        chk("rst_rdata", 32'(rd0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_udf", 32'(udf0), 32'd0);

        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            chk("fill_count", 32'(count0), 32'(i + 1));
            chk("fill_af", 32'(af0), 32'((i + 1) >= 6));
            chk("fill_full", 32'(full0), 32'((i + 1) == 8));
            if (i == 0) chk("fwft_first_word", 32'(rd1), 32'h10);
        end

        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(count0), 32'd8);
        chk("ovf_set", 32'(ovf0), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(ovf0), 32'd1);

        cyc(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        chk("full_rw_count", 32'(count0), 32'd8);
        chk("full_rw_rdata", 32'(rd0), 32'h10);
        chk("full_rw_fwft", 32'(rd1), 32'h11);

        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("drain_rdata", 32'(rd0), 32'(8'h10 + i));
            chk("drain_count", 32'(count0), 32'(8 - i));
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_last", 32'(rd0), 32'hBB);
        chk("drain_empty", 32'(empty0), 32'd1);
        chk("drain_udf_clear", 32'(udf0), 32'd0);

        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("udf_set", 32'(udf0), 32'd1);
        chk("udf_count", 32'(count0), 32'd1);
        chk("udf_rdata_hold", 32'(rd0), 32'hBB);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("udf_readback", 32'(rd0), 32'h55);
        chk("udf_sticky", 32'(udf0), 32'd1);

        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            chk("wrap_count_w", 32'(count0), 32'd1);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("wrap_rdata", 32'(rd0), 32'(8'h60 + i));
            chk("wrap_count_r", 32'(count0), 32'd0);
        end

        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_clr_count", 32'(count0), 32'd5);
        chk("pre_clr_ovf", 32'(ovf0), 32'd1);
        cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        chk("clr_count", 32'(count0), 32'd0);
        chk("clr_empty", 32'(empty0), 32'd1);
        chk("clr_ovf", 32'(ovf0), 32'd0);
        chk("clr_udf", 32'(udf0), 32'd0);
        chk("clr_rdata_kept", 32'(rd0), 32'h73);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("clr_write_ignored", 32'(udf0), 32'd1);
        chk("clr_rdata_hold", 32'(rd0), 32'h73);

        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count0), 32'd5);
        chk("pre_rst_ovf", 32'(ovf0), 32'd1);
        chk("pre_rst_rdata", 32'(rd0), 32'h32);
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("mrst_count", 32'(count0), 32'd0);
        chk("mrst_empty", 32'(empty0), 32'd1);
        chk("mrst_full", 32'(full0), 32'd0);
        chk("mrst_af", 32'(af0), 32'd0);
        chk("mrst_ovf", 32'(ovf0), 32'd0);
        chk("mrst_udf", 32'(udf0), 32'd0);
        chk("mrst_rdata", 32'(rd0), 32'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("mrst_write_ignored", 32'(udf0), 32'd1);
        chk("mrst_count_after", 32'(count0), 32'd0);

        cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("fwft_visible", 32'(rd1), 32'h3C);
        chk("fwft_not_empty", 32'(empty1), 32'd0);
        chk("reg_no_read_yet", 32'(rd0), 32'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("fwft_hold", 32'(rd1), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_count", 32'(count1), 32'd0);
        chk("reg_pop_rdata", 32'(rd0), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/generic_fifo_v2.md
GENERIC_FIFO_V2 -- requirements
Module: generic_fifo_v2

Interface
Parameters:
REQ-001 The block SHALL have parameter GENERIC_FIFO_DEPTH, default 8: number of entries; power of two, >= 2.
REQ-002 The block SHALL have parameter GENERIC_FIFO_DATA_WIDTH, default 32: entry width in bits.
REQ-003 The block SHALL have parameter GENERIC_FIFO_THRESHOLD, default 2: almost_full slack in entries; 0 <= value < DEPTH.
REQ-004 The block SHALL have parameter GENERIC_FIFO_FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-005 The block SHALL define localparam AW = $clog2(GENERIC_FIFO_DEPTH) for pointer width.
Ports:
REQ-006 The block SHALL have clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 The block SHALL have reset_poweron, input, 1: reset, synchronous, active-high.
REQ-008 The block SHALL have clear, input, 1: synchronous flush.
REQ-009 The block SHALL have write, input, 1: push request.
REQ-010 The block SHALL have write_data, input, DATA_WIDTH: push data.
REQ-011 The block SHALL have read, input, 1: pop request.
REQ-012 The block SHALL have read_data, output, DATA_WIDTH: pop data.
REQ-013 The block SHALL have empty, output, 1: count == 0.
REQ-014 The block SHALL have full, output, 1: count == DEPTH.
REQ-015 The block SHALL have almost_full, output, 1: count >= DEPTH-THRESHOLD.
REQ-016 The block SHALL have count, output, AW+1: current occupancy, 0..DEPTH.
REQ-017 The block SHALL have overflow, output, 1: sticky, set on a rejected write.
REQ-018 The block SHALL have underflow, output, 1: sticky, set on a rejected read.

Function
REQ-019 The block SHALL accept a read (rd_acc) iff read & ~empty.
REQ-020 The block SHALL accept a write (wr_acc) iff write & (~full | rd_acc); a write to a full FIFO with a concurrent accepted read therefore succeeds.
REQ-021 The block SHALL, on wr_acc, store write_data at wp and advance wp by 1 modulo DEPTH.
REQ-022 The block SHALL, on rd_acc, advance rp by 1 modulo DEPTH.
REQ-023 The block SHALL update count as +1 on wr_acc only, -1 on rd_acc only, and unchanged on both or neither; count never leaves 0..DEPTH.
REQ-024 The block SHALL derive empty, full and almost_full combinationally from registered count.
REQ-025 The block SHALL NOT derive full from pointer equality.
REQ-026 The block SHALL, on write & ~wr_acc, leave storage and pointers unchanged and set overflow the next cycle; overflow holds until reset or clear.
REQ-027 The block SHALL, on read & empty, leave pointers unchanged, leave read_data unchanged, and set underflow; underflow holds until reset or clear.
REQ-028 The block SHALL, on a simultaneous read and write while empty, accept the write, reject the read and set underflow; there is no bypass.
REQ-029 The block SHALL, when FWFT=0, load read_data with mem[rp] at the clock edge of rd_acc, giving 1-cycle latency; read_data holds otherwise.
REQ-030 The block SHALL, when FWFT=1, drive read_data combinationally as mem[rp]; read_data is valid whenever ~empty, and rd_acc pops that word.
REQ-031 The block SHALL make the first written word visible at read_data in FWFT mode on the cycle after wr_acc.
REQ-032 The block SHALL apply clear in the cycle it is asserted: wp, rp and count go to 0, and overflow and underflow go to 0; concurrent write and read are ignored.
REQ-033 The block SHALL NOT reset storage or read_data on clear.
REQ-034 The block SHALL give priority in the order reset_poweron > clear > read/write.

Reset
REQ-035 The block SHALL, on reset_poweron (sync, active-high), set wp=0, rp=0, count=0, overflow=0, underflow=0, and read_data=0 when FWFT=0.
REQ-036 The block SHALL, as a consequence of reset, drive empty=1, full=0 and almost_full=0.
REQ-037 The block SHALL NOT reset the storage array.
REQ-038 The block SHALL, for reset asserted mid-operation, discard all contents and present the above values on the next cycle, ignoring concurrent write and read.

Verification (DEPTH=8, WIDTH=8, THRESHOLD=2)
REQ-039 The bench SHALL cover fill/drain: write 0x10..0x17 on 8 cycles -> count 1..8, almost_full from count=6, full at 8; then read 8 cycles -> data 0x10..0x17 in order (FWFT=0 one cycle after each read), empty=1 at end.
REQ-040 The bench SHALL cover overflow: FIFO full, write 0xAA alone -> count stays 8, overflow=1 sticky; then read+write 0xBB together -> count 8, 0xBB emerges last.
REQ-041 The bench SHALL cover underflow: empty, read+write 0x55 together -> underflow=1, count=1; next-cycle read returns 0x55.
REQ-042 The bench SHALL cover wrap-around: 20 alternating write/read pairs with an incrementing pattern -> every word returned in order, count never > 1.
REQ-043 The bench SHALL cover FWFT=1: write 0x3C -> read_data=0x3C next cycle with no read; read -> empty=1.
REQ-044 The bench SHALL cover clear/reset mid-stream: count=5 with overflow set, assert clear with write=1 -> count=0, empty=1, overflow=0, write ignored; repeat using reset_poweron -> same, plus read_data=0 when FWFT=0.
